dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit data-memory words (power of two, 16..4096).
REQ-002 SHALL have parameter DONE_ADR, default 32'hFFFF_FFF0, byte address of the done/status register.
REQ-003 SHALL have parameter CYC_ADR, default 32'hFFFF_FFF4, byte address of the cycle-counter register.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 MemWrite  input  1  CPU store strobe, one word per asserted cycle.
REQ-007 DataAdr  input  32  CPU byte address for load and store.
REQ-008 WriteData  input  32  CPU store data.
REQ-009 ReadData  output  32  registered load data.
REQ-010 Done  output  1  sticky program-complete flag.
REQ-011 DoneCode  output  32  value the program wrote to DONE_ADR.
REQ-012 AdrErr  output  1  sticky illegal-access flag.

Function
REQ-013 Word index SHALL be DataAdr[log2(DEPTH)+1:2]; an address is in-range when DataAdr < DEPTH*4.
REQ-014 An access (load sampled every cycle, or store when MemWrite=1) SHALL be misaligned when DataAdr[1:0] != 0.
REQ-015 In-range aligned store SHALL write WriteData to mem[index] at the rising edge.
REQ-016 ReadData SHALL equal the addressed value one cycle after DataAdr is presented (latency 1, every cycle).
REQ-017 Same-cycle store and load to one word SHALL return the old contents (read-first); the new value is visible the following cycle.
REQ-018 Load from DONE_ADR SHALL return DoneCode; load from any other out-of-range or misaligned address SHALL return 0.
REQ-019 Store to DONE_ADR while Done=0 SHALL set Done=1 and DoneCode=WriteData on the same edge.
REQ-020 Store to DONE_ADR while Done=1 SHALL be ignored (first write wins); AdrErr unaffected.
REQ-021 Store to any non-register out-of-range or misaligned address SHALL leave memory unchanged and set AdrErr=1.
REQ-022 Misaligned or non-register out-of-range load SHALL set AdrErr=1 only when MemWrite=0 and the previous cycle's DataAdr equals the current one (stable address), avoiding false flags on address transitions.
REQ-023 AdrErr and Done SHALL remain set until reset.
REQ-024 Memory SHALL be single-port behaviour: one store and one load per cycle; no stalls, no back-pressure.

Reset
REQ-025 When reset=0 at a rising edge: ReadData=0, Done=0, DoneCode=0, AdrErr=0, cycle counter=0, previous-address register=0.
REQ-026 Reset SHALL dominate a same-cycle store: no memory or register write occurs.
REQ-027 Memory contents SHALL NOT be cleared by reset; contents after power-up are undefined unless preloaded by the bench.
REQ-028 Reset asserted mid-program SHALL clear Done so a rerun can report a new DoneCode.

Configuration
REQ-029 Macro DMEM_CYCLE_COUNTER_EN, when defined, SHALL include a 32-bit cycle counter incrementing every cycle with reset=1 and Done=0, wrapping 32'hFFFF_FFFF->0, frozen once Done=1, readable at CYC_ADR; stores to CYC_ADR ignored without AdrErr.
REQ-030 Without DMEM_CYCLE_COUNTER_EN, no counter logic SHALL exist and CYC_ADR SHALL behave as any other out-of-range address (load returns 0, store sets AdrErr).

Verification
REQ-031 Store 0x1234_5678 to 0x10, then load 0x10 -> ReadData=0x1234_5678 one cycle after address presented.
REQ-032 mem[4]=0xAAAA_AAAA; same cycle store 0x5555_5555 and load 0x10 -> ReadData=0xAAAA_AAAA, next cycle 0x5555_5555.
REQ-033 Store 0x0000_00A4 to DONE_ADR, then store 0xDEAD_BEEF to DONE_ADR -> Done=1, DoneCode stays 0x0000_00A4, load DONE_ADR returns 0x0000_00A4.
REQ-034 Store to 0x0000_0401 (misaligned) and to 0x0000_0400 with DEPTH=256 -> AdrErr=1, mem[0] and mem[1] unchanged.
REQ-035 With DMEM_CYCLE_COUNTER_EN, release reset, run 100 cycles, store to DONE_ADR, wait 10 cycles, load CYC_ADR -> value 100 (frozen); without macro the load returns 0 and AdrErr=1 on store to CYC_ADR.
REQ-036 Assert reset=0 for one cycle while Done=1 and MemWrite=1 to address 0x8 -> Done=0, DoneCode=0, AdrErr=0, ReadData=0, mem[2] unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a single-cycle CPU test harness.
//
// Holds a DEPTH-word, 32-bit data memory. Loads are registered with
// latency 1 and read-first against a same-cycle store. It also decodes
// two memory-mapped registers above the RAM:
//   DONE_ADR : the first store sets the sticky Done flag and latches DoneCode.
//              Later stores are ignored. A load returns DoneCode.
//   CYC_ADR  : a free-running cycle counter that freezes once Done is set.
//              It exists only when DMEM_CYCLE_COUNTER_EN is defined.
//              Otherwise this address decodes like any other out-of-range address.
// Illegal accesses set the sticky AdrErr flag. An illegal access is a
// misaligned access, or an out-of-range access that does not hit a register.
//
// Optional feature macro: DMEM_CYCLE_COUNTER_EN
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous active-low reset
//   MemWrite   in   1   store strobe
//   DataAdr    in   32  byte address (load every cycle, store when MemWrite)
//   WriteData  in   32  store data
//   ReadData   out  32  registered load data
//   Done       out  1   sticky program-complete flag
//   DoneCode   out  32  value first written to DONE_ADR
//   AdrErr     out  1   sticky illegal-access flag
module dmem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] DONE_ADR = 32'hFFFF_FFF0,
  parameter logic [31:0] CYC_ADR  = 32'hFFFF_FFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic [31:0] DoneCode,
  output logic        AdrErr
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  // Elaboration-time guards against an unusable configuration.
  if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two in 16..4096");
  end
  if (DONE_ADR[1:0] != 2'b00 || CYC_ADR[1:0] != 2'b00) begin : g_bad_reg_adr
    $error("dmem_responder: register addresses must be word aligned");
  end

  logic [31:0] mem [DEPTH];
  logic [31:0] prev_adr;
  logic [AW-1:0] idx;
  logic        misal, in_range, mem_ok;
  logic        hit_done, hit_cyc, bad_adr;
  logic        mem_we, load_err;
  logic [31:0] cyc_val;
  logic [31:0] rd_next;

  assign idx      = DataAdr[AW+1:2];
  assign misal    = (DataAdr[1:0] != 2'b00);
  assign in_range = (DataAdr < MEM_BYTES);
  assign mem_ok   = in_range & ~misal;
  assign hit_done = (DataAdr == DONE_ADR);

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;

  assign hit_cyc = (DataAdr == CYC_ADR);
  assign cyc_val = cyc_cnt;

  // The counter freezes once Done is set, so the program's runtime can be
  // read back after completion. It wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset)
      cyc_cnt <= '0;
    else if (!Done)
      cyc_cnt <= cyc_cnt + 32'd1;
  end
`else
  assign hit_cyc = 1'b0;
  assign cyc_val = '0;
`endif

  // Not RAM and not a decoded register: this is an illegal address.
  assign bad_adr = ~mem_ok & ~hit_done & ~hit_cyc;

  assign mem_we = reset & MemWrite & mem_ok;

  // A load is flagged only if the address is held for a second cycle.
  // Otherwise the transient addresses a CPU drives while its address path
  // settles would raise false errors.
  assign load_err = ~MemWrite & bad_adr & (DataAdr == prev_adr);

  always_comb begin
    rd_next = '0;
    if (mem_ok)
      rd_next = mem[idx];
    else if (hit_done)
      rd_next = DoneCode;
    else if (hit_cyc)
      rd_next = cyc_val;
  end

  // Memory is not reset. The non-blocking write makes a same-cycle load see
  // the old contents (read-first).
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ReadData <= '0;
      prev_adr <= '0;
      Done     <= 1'b0;
      DoneCode <= '0;
      AdrErr   <= 1'b0;
    end else begin
      ReadData <= rd_next;
      prev_adr <= DataAdr;
      if (MemWrite && hit_done && !Done) begin
        Done     <= 1'b1;
        DoneCode <= WriteData;
      end
      if ((MemWrite && bad_adr) || load_err)
        AdrErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [31:0] DONE_ADR = 32'hFFFF_FFF0;
  localparam logic [31:0] CYC_ADR  = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Done;
  logic [31:0] DoneCode;
  logic        AdrErr;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.DEPTH(256), .DONE_ADR(DONE_ADR), .CYC_ADR(CYC_ADR)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ReadData(ReadData), .Done(Done),
    .DoneCode(DoneCode), .AdrErr(AdrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_rdata",  ReadData, 32'h0);
    chk("rst_done",   Done,     32'h0);
    chk("rst_code",   DoneCode, 32'h0);
    chk("rst_adrerr", AdrErr,   32'h0);
    reset = 1'b1;

    // Store then load, latency 1
    drive(1'b1, 32'h10, 32'h1234_5678); tick();
    drive(1'b0, 32'h10, 32'h0);         tick();
    chk("st_ld_0x10", ReadData, 32'h1234_5678);

    // Read-first on same-cycle store/load
    drive(1'b1, 32'h10, 32'hAAAA_AAAA); tick();
    drive(1'b1, 32'h10, 32'h5555_5555); tick();
    chk("rd_first_old", ReadData, 32'hAAAA_AAAA);
    drive(1'b0, 32'h10, 32'h0); tick();
    chk("rd_first_new", ReadData, 32'h5555_5555);

    // Fill a few words including the last, then pipelined readback
    drive(1'b1, 32'h000, 32'h1111_1111); tick();
    drive(1'b1, 32'h004, 32'h2222_2222); tick();
    drive(1'b1, 32'h008, 32'h3333_3333); tick();
    drive(1'b1, 32'h3FC, 32'hCAFE_F00D); tick();
    drive(1'b0, 32'h000, 32'h0); tick(); chk("rd_w0",   ReadData, 32'h1111_1111);
    drive(1'b0, 32'h004, 32'h0); tick(); chk("rd_w1",   ReadData, 32'h2222_2222);
    drive(1'b0, 32'h3FC, 32'h0); tick(); chk("rd_w255", ReadData, 32'hCAFE_F00D);
    chk("no_err_legal", AdrErr, 32'h0);

    // Transient misaligned / out-of-range loads: return 0, no flag
    drive(1'b0, 32'h005, 32'h0); tick(); chk("misal_ld_zero", ReadData, 32'h0);
    drive(1'b0, 32'h800, 32'h0); tick(); chk("oor_ld_zero",   ReadData, 32'h0);
    drive(1'b0, 32'h008, 32'h0); tick(); chk("rd_w2",         ReadData, 32'h3333_3333);
    chk("transient_no_err", AdrErr, 32'h0);

    // Out-of-range store
    drive(1'b1, 32'h400, 32'hBAD0_BAD0); tick();
    chk("oor_st_err", AdrErr, 32'h1);
    do_reset();
    chk("err_cleared", AdrErr, 32'h0);
    // Misaligned store
    drive(1'b1, 32'h401, 32'hBAD1_BAD1); tick();
    chk("misal_st_err", AdrErr, 32'h1);
    drive(1'b0, 32'h000, 32'h0); tick(); chk("w0_intact", ReadData, 32'h1111_1111);
    drive(1'b0, 32'h004, 32'h0); tick(); chk("w1_intact", ReadData, 32'h2222_2222);

    // Stable misaligned load flags on the second cycle
    do_reset();
    drive(1'b0, 32'h006, 32'h0); tick();
    chk("stable_ld_1st", AdrErr, 32'h0);
    tick();
    chk("stable_ld_2nd", AdrErr, 32'h1);
    do_reset();

    // Done register, first write wins
    drive(1'b1, DONE_ADR, 32'h0000_00A4); tick();
    chk("done_set",  Done,     32'h1);
    chk("done_code", DoneCode, 32'h0000_00A4);
    drive(1'b1, DONE_ADR, 32'hDEAD_BEEF); tick();
    chk("done_keep", DoneCode, 32'h0000_00A4);
    chk("done_noerr", AdrErr,  32'h0);
    drive(1'b0, DONE_ADR, 32'h0); tick();
    chk("done_ld", ReadData, 32'h0000_00A4);

`ifdef DMEM_CYCLE_COUNTER_EN
    // 99 idle edges plus the store edge give 100 counted cycles.
    do_reset();
    repeat (99) tick();
    drive(1'b1, DONE_ADR, 32'h0000_00A4); tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (10) tick();
    drive(1'b0, CYC_ADR, 32'h0); tick();
    chk("cyc_frozen", ReadData, 32'd100);
    drive(1'b1, CYC_ADR, 32'h1234); tick();
    chk("cyc_st_noerr", AdrErr, 32'h0);
    drive(1'b0, CYC_ADR, 32'h0); tick();
    chk("cyc_st_ignored", ReadData, 32'd100);
`else
    drive(1'b0, CYC_ADR, 32'h0); tick();
    chk("cyc_ld_zero", ReadData, 32'h0);
    chk("cyc_ld_noerr", AdrErr, 32'h0);
    drive(1'b1, CYC_ADR, 32'h1234); tick();
    chk("cyc_st_err", AdrErr, 32'h1);
`endif

    // Reset dominates a store while Done=1
    drive(1'b0, 32'h0, 32'h0); tick();
    reset = 1'b0;
    drive(1'b1, 32'h008, 32'hFFFF_0000); tick();
    reset = 1'b1;
    chk("rst2_done",   Done,     32'h0);
    chk("rst2_code",   DoneCode, 32'h0);
    chk("rst2_adrerr", AdrErr,   32'h0);
    chk("rst2_rdata",  ReadData, 32'h0);
    drive(1'b0, 32'h008, 32'h0); tick();
    chk("rst2_w2_intact", ReadData, 32'h3333_3333);

    // Rerun reports a new code
    drive(1'b1, DONE_ADR, 32'h0000_0077); tick();
    chk("rerun_done", Done,     32'h1);
    chk("rerun_code", DoneCode, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
